// File: rtl/trumpet_noise_gate_pkg.sv
// Shared audio definitions for the trumpet enhancement chain: sample format,
// Q1.15 unity gain, gate state encoding and saturating helpers.
package trumpet_noise_gate_pkg;

  localparam int          SAMPLE_W  = 16;
  localparam logic [16:0] Q15_UNITY = 17'd32768;

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_ATTACK,
    ST_OPEN,
    ST_HOLD,
    ST_RELEASE
  } gate_state_e;

  // |x| with the one unrepresentable magnitude (-32768) saturated to 32767.
  function automatic logic [15:0] abs16(input logic signed [15:0] x);
    if (x == 16'sh8000) return 16'd32767;
    else if (x[15])     return 16'(-x);
    else                return 16'(x);
  endfunction

  function automatic logic signed [15:0] clamp16(input logic signed [32:0] v);
    if (v > 33'sd32767)       return 16'sh7fff;
    else if (v < -33'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/trumpet_env_follower.sv
// One-pole envelope follower on |sample|; the level only moves on accepted
// samples so the gate FSM and the envelope stay in step.
module trumpet_env_follower
  import trumpet_noise_gate_pkg::*;
#(
  parameter int ENV_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_i,
  input  logic [15:0] sample_i,
  output logic [15:0] env_o
);

  logic        [15:0] env_q, env_d;
  logic        [15:0] abs_val;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [17:0] sum;

  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    abs_val = abs16($signed(sample_i));
    diff    = $signed({1'b0, abs_val}) - $signed({1'b0, env_q});
    step    = diff >>> ENV_SHIFT;
    sum     = 18'(step) + $signed({2'b00, env_q});
    if (sum < 18'sd0)          env_d = 16'd0;
    else if (sum > 18'sd32767) env_d = 16'd32767;
    else                       env_d = sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst)        env_q <= '0;
    else if (upd_i) env_q <= env_d;
  end

  assign env_o = env_q;

endmodule

// File: rtl/trumpet_noise_gate.sv
// Noise gate ahead of the trumpet warmer: envelope-driven hysteresis/hold/
// release FSM ramps a Q1.15 gain applied to the sample in a 2-stage pipeline.
module trumpet_noise_gate
  import trumpet_noise_gate_pkg::*;
#(
  parameter int OPEN_THRESH  = 1024,
  parameter int CLOSE_THRESH = 512,
  parameter int HOLD_SAMPLES = 2400,
  parameter int ENV_SHIFT    = 4,
  parameter int ATTACK_STEP  = 2048,
  parameter int RELEASE_STEP = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [15:0] in_sample,
  output logic        out_valid,
  output logic [15:0] out_sample,
  output logic        gate_open,
  output logic [15:0] gain
);

  localparam int              HOLD_W    = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [15:0]     OPEN_LVL  = 16'(OPEN_THRESH);
  localparam logic [15:0]     CLOSE_LVL = 16'(CLOSE_THRESH);
  localparam logic [16:0]     ATT_INC   = 17'(ATTACK_STEP);
  localparam logic [15:0]     REL_DEC   = 16'(RELEASE_STEP);
  localparam logic [15:0]     GAIN_MAX  = 16'h8000;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);

  gate_state_e       state_q, state_d;
  logic [15:0]       gain_q, gain_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              gate_open_q, gate_open_d;
  logic [16:0]       gain_up;
  logic [15:0]       env;
  logic              upd;

  assign upd = in_valid & enable;

  trumpet_env_follower #(
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .clk      (clk),
    .rst      (rst),
    .upd_i    (upd),
    .sample_i (in_sample),
    .env_o    (env)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLOSED;
      gain_q      <= '0;
      hold_q      <= '0;
      gate_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      hold_q      <= hold_d;
      gate_open_q <= gate_open_d;
    end
  end

  // Threshold tests use the envelope before this sample updates it; a
  // re-open request always wins over hold expiry and the release floor.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    gain_up = {1'b0, gain_q} + ATT_INC;
    if (upd) begin
      unique case (state_q)
        ST_CLOSED: begin
          gain_d = '0;
          if (env >= OPEN_LVL) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (gain_up >= Q15_UNITY) begin
            gain_d  = GAIN_MAX;
            state_d = ST_OPEN;
          end else begin
            gain_d = gain_up[15:0];
          end
        end
        ST_OPEN: begin
          if (env < CLOSE_LVL) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (env >= OPEN_LVL) begin
            state_d = ST_OPEN;
            hold_d  = '0;
          end else if (hold_q == '0) begin
            state_d = ST_RELEASE;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (env >= OPEN_LVL) begin
            state_d = ST_ATTACK;
          end else if (gain_q <= REL_DEC) begin
            gain_d  = '0;
            state_d = ST_CLOSED;
          end else begin
            gain_d = gain_q - REL_DEC;
          end
        end
        default: begin
          state_d = ST_CLOSED;
          gain_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    gate_open_d = (state_d == ST_ATTACK) || (state_d == ST_OPEN) || (state_d == ST_HOLD);
  end

  logic               s1_valid_q;
  logic [15:0]        s1_sample_q;
  logic [16:0]        s1_gain_q;
  logic               out_valid_q;
  logic [15:0]        out_sample_q;
  logic signed [32:0] mul_a, mul_b, prod, prod_sh;
  logic signed [15:0] mul_out;

  always_comb begin
    mul_a   = 33'($signed(s1_sample_q));
    mul_b   = $signed({16'd0, s1_gain_q});
    prod    = mul_a * mul_b;
    prod_sh = prod >>> 15;
    mul_out = clamp16(prod_sh);
  end

  // Stage 1 freezes the pre-update gain (unity in bypass); stage 2 scales.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sample_q  <= '0;
      s1_gain_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sample_q <= in_sample;
        s1_gain_q   <= enable ? {1'b0, gain_q} : Q15_UNITY;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) out_sample_q <= mul_out;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign gate_open  = gate_open_q;
  assign gain       = gain_q;

endmodule

// File: tb/tb_trumpet_noise_gate.sv
// Randomised scoreboard bench for trumpet_noise_gate against a behavioural
// gate model; outputs are checked by an independent negedge monitor.
module tb_trumpet_noise_gate;

  localparam int P_OPEN  = 1024;
  localparam int P_CLOSE = 512;
  localparam int P_HOLD  = 4;
  localparam int P_SHIFT = 0;
  localparam int P_ATT   = 2048;
  localparam int P_REL   = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_sample = '0;
  logic               out_valid;
  logic signed [15:0] out_sample;
  logic               gate_open;
  logic [15:0]        gain;

  trumpet_noise_gate #(
    .OPEN_THRESH  (P_OPEN),
    .CLOSE_THRESH (P_CLOSE),
    .HOLD_SAMPLES (P_HOLD),
    .ENV_SHIFT    (P_SHIFT),
    .ATTACK_STEP  (P_ATT),
    .RELEASE_STEP (P_REL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .gate_open  (gate_open),
    .gain       (gain)
  );

  always #5 clk = ~clk;

  typedef enum {M_CLOSED, M_ATTACK, M_OPEN, M_HOLD, M_RELEASE} mstate_e;

  mstate_e m_st   = M_CLOSED;
  int      m_env  = 0;
  int      m_gain = 0;
  int      m_hold = 0;
  int      sb_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  bit      p1 = 1'b0;
  bit      p2 = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_abs(input int s);
    if (s == -32768) return 32767;
    return (s < 0) ? -s : s;
  endfunction

  function automatic int ref_clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int ref_open();
    return (m_st == M_ATTACK || m_st == M_OPEN || m_st == M_HOLD) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_st = M_CLOSED; m_env = 0; m_gain = 0; m_hold = 0;
  endtask

  // One accepted, enabled sample: decide from the old envelope, then smooth.
  task automatic model_step(input int s);
    int env_old;
    env_old = m_env;
    case (m_st)
      M_CLOSED: begin
        m_gain = 0;
        if (env_old >= P_OPEN) m_st = M_ATTACK;
      end
      M_ATTACK: begin
        m_gain = (m_gain + P_ATT > 32768) ? 32768 : m_gain + P_ATT;
        if (m_gain == 32768) m_st = M_OPEN;
      end
      M_OPEN: begin
        if (env_old < P_CLOSE) begin m_st = M_HOLD; m_hold = P_HOLD - 1; end
      end
      M_HOLD: begin
        if (env_old >= P_OPEN) begin m_st = M_OPEN; m_hold = 0; end
        else if (m_hold == 0) m_st = M_RELEASE;
        else m_hold--;
      end
      M_RELEASE: begin
        if (env_old >= P_OPEN) m_st = M_ATTACK;
        else begin
          m_gain = (m_gain - P_REL < 0) ? 0 : m_gain - P_REL;
          if (m_gain == 0) m_st = M_CLOSED;
        end
      end
      default: m_st = M_CLOSED;
    endcase
    m_env = ref_clamp(env_old + ((ref_abs(s) - env_old) >>> P_SHIFT), 0, 32767);
  endtask

  // Present one cycle of input, predict, then check the live gain/gate state.
  task automatic drive(input bit v, input bit en, input int s);
    int eff;
    in_valid  = v;
    enable    = en;
    in_sample = 16'(s);
    if (v) begin
      eff = en ? m_gain : 32768;
      sb_q.push_back(ref_clamp((s * eff) >>> 15, -32768, 32767));
      if (en) model_step(s);
    end
    @(posedge clk);
    #1;
    check("gain", gain, m_gain);
    check("gate_open", gate_open, ref_open());
  endtask

  initial begin : monitor
    int exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        p1 = 1'b0;
        p2 = 1'b0;
        check("out_valid_in_reset", out_valid, 0);
      end else begin
        check("out_valid_latency", out_valid, p2);
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_sample: unexpected output %0d, expected none", out_sample);
          end else begin
            exp = sb_q.pop_front();
            check("out_sample", out_sample, exp);
          end
        end
        p2 = p1;
        p1 = in_valid;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int guard;
    int mode;
    int s;
    bit v, en;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_gate_open", gate_open, 0);
    check("rst_gain", gain, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Silence keeps the gate shut.
    for (int i = 0; i < 100; i++) drive(1, 1, 0);

    // Steady note: attack begins on the 2nd sample, 16 steps to unity.
    for (int i = 0; i < 17; i++) drive(1, 1, 2000);
    check("attack_gain_17", gain, 30720);
    drive(1, 1, 2000);
    check("attack_gain_18", gain, 32768);
    check("attack_open_18", gate_open, 1);

    // Release down to one step above half gain, then re-trigger.
    guard = 0;
    while (m_gain != 16448 && guard < 1000) begin drive(1, 1, 0); guard++; end
    check("release_gain_16448", gain, 16448);
    drive(1, 1, 2000);
    drive(1, 1, 2000);
    check("reattack_start_gain", gain, 16384);
    check("reattack_gate_open", gate_open, 1);
    for (int i = 0; i < 8; i++) drive(1, 1, 2000);
    check("reattack_gain_8", gain, 32768);

    // Bypass passes extremes untouched and freezes the gate.
    drive(1, 0, -32768);
    drive(1, 0, 5);
    drive(1, 0, 32767);
    check("bypass_gain_frozen", gain, 32768);
    check("bypass_gate_frozen", gate_open, 1);

    // Full release to closed.
    guard = 0;
    while (m_st != M_CLOSED && guard < 1000) begin drive(1, 1, 0); guard++; end
    check("closed_gate", gate_open, 0);
    check("closed_gain", gain, 0);

    // Randomised segments: quiet, full-scale, extremes, near-threshold.
    for (int seg = 0; seg < 60; seg++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < 40; i++) begin
        v  = ($urandom_range(0, 9) < 8);
        en = ($urandom_range(0, 19) != 0);
        case (mode)
          0:       s = int'($urandom_range(0, 600)) - 300;
          1:       s = int'($urandom_range(0, 65535)) - 32768;
          2: begin
            case ($urandom_range(0, 3))
              0:       s = -32768;
              1:       s = 32767;
              2:       s = -1;
              default: s = 0;
            endcase
          end
          default: s = int'($urandom_range(0, 4000)) - 2000;
        endcase
        drive(v, en, s);
      end
    end

    // Async reset while open with samples in flight.
    guard = 0;
    while (m_st != M_OPEN && guard < 100) begin drive(1, 1, 2000); guard++; end
    check("pre_reset_gate_open", gate_open, 1);
    drive(1, 1, 1500);
    in_valid  = 1'b1;
    enable    = 1'b1;
    in_sample = 16'sd1700;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sample", out_sample, 0);
    check("midrst_gate_open", gate_open, 0);
    check("midrst_gain", gain, 0);
    sb_q.delete();
    model_reset();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1, 1, 0);
    check("post_reset_closed", gate_open, 0);

    for (int i = 0; i < 3; i++) drive(0, 1, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trumpet_noise_gate.md
Name: trumpet_noise_gate

Overview:
- Gating stage directly upstream of the trumpet warming stage in the trumpet enhancement chain.
- Suppresses breath and valve noise between notes by multiplying each signed 16-bit sample by a ramped gain.
- The gain is driven by an envelope follower and a hysteresis/hold/release state machine.
- Output feeds the warmer's in_sample unchanged in format.

Parameters:
- OPEN_THRESH, 1024: envelope level (unsigned, 0..32767) at or above which the gate opens.
- CLOSE_THRESH, 512: envelope level below which the gate starts closing. Must be <= OPEN_THRESH.
- HOLD_SAMPLES, 2400: valid samples held open after envelope drops below CLOSE_THRESH. Must be >= 1.
- ENV_SHIFT, 4: envelope smoothing shift; larger means slower.
- ATTACK_STEP, 2048: gain increment per valid sample in ATTACK.
- RELEASE_STEP, 64: gain decrement per valid sample in RELEASE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = gate active; 0 = unity-gain bypass
- in_valid  in  1  in_sample qualifier; may be high every cycle
- in_sample  in  16  signed PCM sample
- out_valid  out  1  out_sample qualifier
- out_sample  out  16  signed gated sample
- gate_open  out  1  high in ATTACK, OPEN, HOLD
- gain  out  16  current gain, unsigned Q1.15; 32768 = unity

Behaviour:
- Reset (async, immediate): out_valid=0, out_sample=0, gate_open=0, gain=0, envelope=0, hold counter=0, state=CLOSED, pipeline valids cleared. Reset mid-stream discards in-flight samples; there is no out_valid pulse for them.
- All envelope, FSM, counter and gain updates occur only on edges where in_valid=1 and enable=1.
- Absolute value: abs = |in_sample|, except -32768 maps to 32767.
- Envelope: env <= env + ((abs - env) >>> ENV_SHIFT), using a 17-bit signed difference and arithmetic shift. Result is clamped to 0..32767.
- Threshold compares use the env value before this sample's update.
- FSM states and transitions:
  - CLOSED: gain held 0. env >= OPEN_THRESH -> ATTACK.
  - ATTACK: gain = min(gain+ATTACK_STEP, 32768). Reaching 32768 -> OPEN. Envelope drop does not abort attack.
  - OPEN: gain 32768. env < CLOSE_THRESH -> HOLD, with hold counter loaded to HOLD_SAMPLES-1.
  - HOLD: gain 32768. env >= OPEN_THRESH -> OPEN, counter cleared. Else counter==0 -> RELEASE. Else counter decrements.
  - RELEASE: gain = max(gain-RELEASE_STEP, 0). Reaching 0 -> CLOSED. env >= OPEN_THRESH -> ATTACK, starting from the current gain with no reset to 0.
  - Precedence when events coincide: re-open check beats counter expiry and gain floor.
- Pipeline, latency 2 edges:
  - Edge 1: capture in_sample and the gain value before this sample's update (effective gain). Update env/FSM/gain.
  - Edge 2: out_sample = clamp16((in_sample * effective_gain) >>> 15), using a signed 16 x unsigned 17 multiply giving a 33-bit product. out_valid = delayed in_valid.
- Throughput is one sample per cycle. out_valid mirrors in_valid delayed by exactly 2 edges. Gaps are preserved.
- Bypass (enable=0):
  - Same 2-edge pipeline, effective gain forced to 32768, so out_sample equals in_sample exactly.
  - FSM, env, counter and gain register are frozen. gate_open and gain outputs show the frozen values.
  - Toggling enable mid-stream only changes the effective gain of samples entering on that edge.
- The gain output is the live gain register. gate_open is registered from the state.

Decomposition:
- Shared audio package holds:
  - sample width 16;
  - Q1.15 unity constant 32768;
  - gate state enum (CLOSED, ATTACK, OPEN, HOLD, RELEASE);
  - clamp16 and abs16 helper functions, reused by the other chain stages.
- One natural sub-module: trumpet_env_follower (abs + smoothing + env register, with enable/in_valid gating). FSM and multiply stay in the top.

Test Plan:
- Reset then 100 samples of 0 at in_valid=1 -> out_sample=0, gate_open=0, gain=0 throughout; out_valid follows in_valid by 2 cycles.
- ENV_SHIFT=0, in_sample=+2000 continuous -> ATTACK on the 2nd valid sample. Gain steps 2048, 4096, ... and reaches 32768 after 16 ATTACK samples. Output ramps to 2000; first nonzero output is 125.
- After OPEN, input drops to 0 with HOLD_SAMPLES=4 -> gain stays 32768 for 4 samples, then falls by 64 per sample to 0 over 512 samples, then CLOSED and gate_open=0.
- During RELEASE at gain=16384, input back to 2000 -> ATTACK resumes from 16384 and reaches 32768 in 8 samples.
- enable=0 with in_sample=-32768, 5, 32767 -> out_sample identical after 2 cycles. FSM, gain and env are unchanged.
- Assert rst asynchronously while OPEN with 2 samples in flight -> outputs zero immediately, no out_valid for those samples; next 0-level input keeps the gate CLOSED.
